// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, vend handshake, change return.
// Optional dispense-ack timeout is enabled with `define VEND_TIMEOUT_EN.
module vend_controller #(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 8,
  parameter int CREDIT_W   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_n,
  input  logic                coin_d,
  input  logic                sel,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                change_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_e;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                disp_req_q;
  logic                change_out_q;
  logic                coin_reject_q;
  logic                busy_q;

  logic [CREDIT_W:0]   coin_add;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_ok;
  logic                coins_in;
  logic [CREDIT_W-1:0] credit_acc;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Coin value this cycle and the credit it would produce if accepted
  assign coin_add   = {{CREDIT_W{1'b0}}, coin_n}
                    + {{(CREDIT_W-1){1'b0}}, coin_d, 1'b0};
  assign credit_sum = {1'b0, credit_q} + coin_add;
  assign coin_ok    = (credit_sum <= MAX_C);
  assign coins_in   = coin_n | coin_d;
  assign credit_acc = coin_ok ? credit_sum[CREDIT_W-1:0] : credit_q;

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      change_out_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_q         <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      change_out_q  <= 1'b0;
      coin_reject_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      fault_q       <= 1'b0;
`endif
      unique case (state_q)
        IDLE, COLLECT: begin
          coin_reject_q <= coins_in & ~coin_ok;
          if (cancel && state_q == COLLECT) begin
            credit_q <= credit_acc;
            state_q  <= CHANGE;
            busy_q   <= 1'b1;
          end else if (sel && credit_q >= PRICE_C) begin
            credit_q   <= credit_acc - PRICE_C;
            state_q    <= VEND;
            busy_q     <= 1'b1;
            disp_req_q <= 1'b1;
`ifdef VEND_TIMEOUT_EN
            tmo_q      <= '0;
`endif
          end else begin
            credit_q <= credit_acc;
            state_q  <= (credit_acc == '0) ? IDLE : COLLECT;
          end
        end
        VEND: begin
          coin_reject_q <= coins_in;
          if (disp_ack) begin
            disp_req_q <= 1'b0;
            if (credit_q != '0) begin
              state_q <= CHANGE;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
`ifdef VEND_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            disp_req_q <= 1'b0;
            fault_q    <= 1'b1;
            credit_q   <= credit_q + PRICE_C;
            state_q    <= CHANGE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        CHANGE: begin
          coin_reject_q <= coins_in;
          if (credit_q != '0) begin
            change_out_q <= 1'b1;
            credit_q     <= credit_q - 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign disp_req    = disp_req_q;
  assign change_out  = change_out_q;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign busy        = busy_q;
`ifdef VEND_TIMEOUT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: vector table through a scoreboard queue,
// plus hand-written refund and long-vend sequences.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst, coin_n, coin_d, sel, cancel, disp_ack;
  logic       disp_req, change_out, coin_reject, busy, fault;
  logic [3:0] credit;

  int errs   = 0;
  int checks = 0;

  vend_controller dut (
    .clk        (clk),
    .rst        (rst),
    .coin_n     (coin_n),
    .coin_d     (coin_d),
    .sel        (sel),
    .cancel     (cancel),
    .disp_ack   (disp_ack),
    .disp_req   (disp_req),
    .change_out (change_out),
    .coin_reject(coin_reject),
    .credit     (credit),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, cn, cd, sel, can, ack;
    logic       dr, co, rj, bz;
    logic [3:0] cr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    logic r, logic cn, logic cd, logic s, logic c, logic a,
    logic dr, logic co, logic rj, logic [3:0] cr, logic bz);
    vec_t v;
    v.rst = r; v.cn = cn; v.cd = cd; v.sel = s; v.can = c; v.ack = a;
    v.dr = dr; v.co = co; v.rj = rj; v.cr = cr; v.bz = bz;
    return v;
  endfunction

  task automatic drive(logic r, logic cn, logic cd,
                       logic s, logic c, logic a);
    @(negedge clk);
    rst = r; coin_n = cn; coin_d = cd;
    sel = s; cancel = c; disp_ack = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d need %0d", nm, act, req);
    end
  endtask

  function automatic logic [8:0] pack_dut();
    return {disp_req, change_out, coin_reject, busy, fault, credit};
  endfunction

  int cnt, first, last, hold;
  bit done;

  initial begin
    rst = 1'b1; coin_n = 0; coin_d = 0;
    sel = 0; cancel = 0; disp_ack = 0;

    //                r  n  d  s  c  a   dr co rj cr bz
    // change after vend
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // exact price
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // insufficient credit, then cancel
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // overflow reject at 7
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 6, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 7, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 1, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 7, 0));
    // both coins from 5 reach 8 exactly, then one more rejects
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 5, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 8, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 1, 8, 0));
    // coin during vend, reset mid-vend
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 5, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  1, 0, 1, 5, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 5, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // sel+cancel+coin: cancel wins, coin refunded; coin in change rejected
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0,  0, 0, 0, 4, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 1, 1, 3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0, 1, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    // sel with a coin in the same cycle
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      vec_t e;
      drive(vecs[i].rst, vecs[i].cn, vecs[i].cd,
            vecs[i].sel, vecs[i].can, vecs[i].ack);
      exp_q.push_back(vecs[i]);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d {dr,co,rj,bz,flt,cr}", i),
          int'(pack_dut()),
          int'({e.dr, e.co, e.rj, e.bz, 1'b0, e.cr}));
    end

    // full 8-unit refund: 8 consecutive change_out cycles
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0, 0); tick();
    end
    chk("credit_full", int'(credit), 8);
    drive(0, 0, 0, 0, 1, 0); tick();
    chk("cancel_busy", int'(busy), 1);
    cnt = 0; first = -1; last = -1; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      drive(0, 0, 0, 0, 0, 0); tick();
      if (change_out) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (!busy) done = 1;
    end
    chk("refund_done", int'(done), 1);
    chk("refund_count", cnt, 8);
    chk("refund_consec", last - first + 1, 8);
    chk("refund_credit", int'(credit), 0);

    // long wait for ack: disp_req must hold, fault stays low
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    hold = 0;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 0, 0, 0); tick();
      if (disp_req && busy && !fault && credit == 4'd1) hold++;
    end
    chk("vend_hold", hold, 40);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("ack_drop", int'({disp_req, change_out}), 0);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("first_change", int'({change_out, credit}), 5'h10);
    cnt = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      drive(0, 0, 0, 0, 0, 0); tick();
      if (change_out) cnt++;
      if (!busy) done = 1;
    end
    chk("vend_idle", int'(done), 1);
    chk("vend_extra_change", cnt, 0);
    chk("vend_fault", int'(fault), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction sequencer for the vending datapath: accumulates coin credit, accepts a product select, drives the dispense mechanism over a req/ack handshake, then returns change one unit per cycle.
- Sits between the coin/button front end and the dispense motor and change-return actuators.
- Credit is counted in units of one nickel (5c); a dime is 2 units.

Parameters:
- PRICE, 3, product price in units (3 = 15c)
- MAX_CREDIT, 8, maximum credit held, in units
- CREDIT_W, 4, width of credit register/output; must hold MAX_CREDIT+2
- TIMEOUT, 255, dispense ack timeout in cycles (used only with optional feature)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- coin_n  input  1  nickel inserted, 1-cycle pulse, +1 unit
- coin_d  input  1  dime inserted, 1-cycle pulse, +2 units
- sel  input  1  product select, 1-cycle pulse
- cancel  input  1  refund request, 1-cycle pulse
- disp_ack  input  1  dispense mechanism done
- disp_req  output  1  dispense request, level, held until ack
- change_out  output  1  one unit of change returned this cycle
- coin_reject  output  1  coin(s) of previous cycle rejected, 1-cycle pulse
- credit  output  CREDIT_W  current credit in units
- busy  output  1  high in VEND or CHANGE
- fault  output  1  dispense timeout pulse (tied 0 without optional feature)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs registered.
- Reset: state IDLE, credit=0, disp_req=0, change_out=0, coin_reject=0, busy=0, fault=0. Reset mid-operation discards credit (no refund) and drops disp_req on the same edge.
- States: IDLE (credit==0), COLLECT (credit>0), VEND, CHANGE.
- Coin add = coin_n + 2*coin_d (0..3). Coins are accepted only in IDLE/COLLECT.
- Coin acceptance: if credit+add <= MAX_CREDIT, credit += add. Otherwise the whole cycle's coins are rejected, credit is unchanged, and coin_reject=1 on the next cycle.
- Coins in VEND/CHANGE are always rejected (coin_reject pulse).
- IDLE/COLLECT: state follows credit (0 -> IDLE, >0 -> COLLECT).
- sel handling:
  - sel with registered credit >= PRICE: next state VEND, credit_next = credit - PRICE + accepted add, disp_req=1 next cycle.
  - sel with credit < PRICE: ignored, no output change.
- cancel in COLLECT -> CHANGE. cancel in IDLE is ignored.
- sel and cancel in the same cycle: cancel wins. Coins accepted that cycle are added and refunded.
- VEND:
  - disp_req held 1 until disp_ack is sampled 1; disp_req=0 the following cycle.
  - Next state CHANGE if credit>0, else IDLE.
  - disp_ack outside VEND is ignored.
  - sel/cancel ignored.
- CHANGE:
  - Each cycle credit>0: change_out=1 and credit -= 1.
  - When credit reaches 0, change_out=0 and state goes to IDLE.
  - Refund of N units takes exactly N consecutive change_out cycles.
  - sel/cancel ignored.
- busy=1 exactly when state is VEND or CHANGE.
- Latency:
  - sel -> disp_req: 1 cycle.
  - disp_ack -> disp_req low: 1 cycle.
  - Then first change_out on the next cycle.
- No arithmetic wrap: credit is bounded by MAX_CREDIT, and subtraction occurs only when credit >= PRICE or >= 1.

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- Defined: a counter runs in VEND. If disp_ack is not seen within TIMEOUT cycles of disp_req rising:
  - disp_req drops;
  - fault pulses 1 cycle;
  - credit += PRICE (restored);
  - state goes to CHANGE, refunding the full credit.
- Undefined: no counter; VEND waits for disp_ack indefinitely; fault constant 0.

Test Plan:
- Change after vend: rst, dime, dime (credit=4), sel -> disp_req=1 next cycle; disp_ack after 3 cycles -> disp_req=0, one change_out cycle, credit=0, IDLE, busy=0.
- Exact price: nickel x3 (credit=3), sel -> vend, ack -> return to IDLE, change_out never asserted.
- Insufficient credit and cancel: credit=2, sel -> ignored (disp_req=0, credit=2); cancel -> change_out high 2 consecutive cycles, credit=0.
- Overflow and simultaneous coins:
  - credit=7, dime -> coin_reject=1 next cycle, credit stays 7.
  - From credit=5, coin_n+coin_d same cycle -> credit=8, no reject.
- Coin during VEND and reset mid-VEND:
  - Coin during VEND -> coin_reject pulse, credit unchanged.
  - rst asserted during VEND -> next cycle disp_req=0, credit=0, IDLE.
- With VEND_TIMEOUT_EN, TIMEOUT=4: credit=3, sel, never ack -> after 4 cycles fault=1 for 1 cycle, disp_req=0, change_out for 3 cycles, credit=0.
